rocc_mem_responder: RTL and testbench

Behavioural memory responder for the RoCC accelerator data-cache port: it sits on the memory side of the accelerator's `mem_req_*` / `mem_resp_*` interface, services 64-bit loads and stores from an internal word array with a fixed, parameterised latency, and echoes request tags. It signals out-of-range or injected faults with a stage-2 `s2_nack`, and exposes a backdoor port for bench preload and checking. It replaces the L1 data cache in unit-level accelerator simulation.

---
 rtl/rocc_mem_responder.sv | 98 +++++++++
 tb/tb_rocc_mem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rocc_mem_responder.sv
// Fixed-latency behavioural memory behind the RoCC data-cache port.
// Loads and stores hit an internal word array; faulted requests are rejected via s2_nack.
module rocc_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           mem_req_valid,
    output logic                           mem_req_ready,
    input  logic [63:0]                    mem_req_addr,
    input  logic [63:0]                    mem_req_tag,
    input  logic                           mem_req_wen,
    input  logic [63:0]                    mem_wdata,
    output logic                           s2_nack,
    output logic                           mem_resp_valid,
    output logic                           mem_resp_replay,
    output logic                           mem_resp_has_data,
    output logic [63:0]                    mem_resp_data_raw,
    output logic [63:0]                    mem_resp_tag,
    input  logic                           stall,
    input  logic                           nack_inject,
    input  logic                           bd_wen,
    input  logic [$clog2(DEPTH_WORDS)-1:0] bd_addr,
    input  logic [63:0]                    bd_wdata,
    output logic [63:0]                    bd_rdata
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [63:0]         mem [DEPTH_WORDS];

    logic                handshake;
    logic                out_of_range;
    logic                fault;
    logic                do_store;
    logic                do_load;
    logic [AW-1:0]       word_idx;
    logic                unused_addr_bits;

    logic [LATENCY-1:0]  pipe_valid;
    logic [LATENCY-1:0]  pipe_has_data;
    logic [63:0]         pipe_data [LATENCY];
    logic [63:0]         pipe_tag  [LATENCY];
    logic [1:0]          nack_pipe;

    assign mem_req_ready    = !reset && !stall;
    assign handshake        = mem_req_valid && mem_req_ready;
    assign word_idx         = mem_req_addr[3 +: AW];
    assign out_of_range     = |mem_req_addr[63:3+AW];
    assign fault            = out_of_range || nack_inject;
    assign do_store         = handshake && !fault && mem_req_wen;
    assign do_load          = handshake && !fault && !mem_req_wen;
    assign unused_addr_bits = ^mem_req_addr[2:0];

    // Store assignment comes last so it overrides a same-edge backdoor write.
    always_ff @(posedge clock) begin
        if (bd_wen) begin
            mem[bd_addr] <= bd_wdata;
        end
        if (do_store) begin
            mem[word_idx] <= mem_wdata;
        end
    end

    // Empty slots carry zeros so the response outputs stay 0 between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid    <= '0;
            pipe_has_data <= '0;
            nack_pipe     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= '0;
                pipe_tag[i]  <= '0;
            end
        end else begin
            pipe_valid[0]    <= do_store || do_load;
            pipe_has_data[0] <= do_load;
            pipe_data[0]     <= do_load ? mem[word_idx] : '0;
            pipe_tag[0]      <= (do_store || do_load) ? mem_req_tag : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i]    <= pipe_valid[i-1];
                pipe_has_data[i] <= pipe_has_data[i-1];
                pipe_data[i]     <= pipe_data[i-1];
                pipe_tag[i]      <= pipe_tag[i-1];
            end
            nack_pipe <= {nack_pipe[0], handshake && fault};
        end
    end

    assign mem_resp_valid    = pipe_valid[LATENCY-1];
    assign mem_resp_has_data = pipe_has_data[LATENCY-1];
    assign mem_resp_data_raw = pipe_data[LATENCY-1];
    assign mem_resp_tag      = pipe_tag[LATENCY-1];
    assign mem_resp_replay   = 1'b0;
    assign s2_nack           = nack_pipe[1];
    assign bd_rdata          = mem[bd_addr];

endmodule

// File: tb/tb_rocc_mem_responder.sv
// Scoreboard bench for rocc_mem_responder: a word-array reference model predicts
// every response/nack at request time; a negedge monitor pops and compares.
module tb_rocc_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 4;

    logic        clock = 0;
    logic        reset = 1;
    logic        mem_req_valid = 0;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr = 0;
    logic [63:0] mem_req_tag = 0;
    logic        mem_req_wen = 0;
    logic [63:0] mem_wdata = 0;
    logic        s2_nack;
    logic        mem_resp_valid;
    logic        mem_resp_replay;
    logic        mem_resp_has_data;
    logic [63:0] mem_resp_data_raw;
    logic [63:0] mem_resp_tag;
    logic        stall = 0;
    logic        nack_inject = 0;
    logic        bd_wen = 0;
    logic [7:0]  bd_addr = 0;
    logic [63:0] bd_wdata = 0;
    logic [63:0] bd_rdata;

    rocc_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_wen(mem_req_wen), .mem_wdata(mem_wdata),
        .s2_nack(s2_nack), .mem_resp_valid(mem_resp_valid),
        .mem_resp_replay(mem_resp_replay), .mem_resp_has_data(mem_resp_has_data),
        .mem_resp_data_raw(mem_resp_data_raw), .mem_resp_tag(mem_resp_tag),
        .stall(stall), .nack_inject(nack_inject),
        .bd_wen(bd_wen), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic        hd;
        logic [63:0] data;
        logic [63:0] tag;
    } exp_t;

    exp_t        rq[$];
    int          nq[$];
    logic [63:0] mref [DEPTH];
    int          edges = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 0;
    bit          bd_chk = 0;
    exp_t        mon_x;

    always @(posedge clock) edges <= edges + 1;

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clock) begin
        if (mon_en) begin
            while (rq.size() > 0 && rq[0].due < edges) begin
                checks++; failures++;
                $display("FAIL resp_missing due=%0d tag=%h now=%0d", rq[0].due, rq[0].tag, edges);
                void'(rq.pop_front());
            end
            while (nq.size() > 0 && nq[0] < edges) begin
                checks++; failures++;
                $display("FAIL nack_missing due=%0d now=%0d", nq[0], edges);
                void'(nq.pop_front());
            end
            checks++;
            if (mem_resp_valid) begin
                if (rq.size() == 0 || rq[0].due != edges) begin
                    failures++;
                    $display("FAIL unexpected_resp cycle=%0d tag=%h", edges, mem_resp_tag);
                end else begin
                    mon_x = rq.pop_front();
                    if (mem_resp_has_data !== mon_x.hd || mem_resp_data_raw !== mon_x.data ||
                        mem_resp_tag !== mon_x.tag) begin
                        failures++;
                        $display("FAIL resp_fields cycle=%0d got hd=%b data=%h tag=%h want hd=%b data=%h tag=%h",
                                 edges, mem_resp_has_data, mem_resp_data_raw, mem_resp_tag,
                                 mon_x.hd, mon_x.data, mon_x.tag);
                    end
                end
            end else if (mem_resp_has_data !== 1'b0 || mem_resp_data_raw !== 64'd0 ||
                         mem_resp_tag !== 64'd0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d got hd=%b data=%h tag=%h want all 0",
                         edges, mem_resp_has_data, mem_resp_data_raw, mem_resp_tag);
            end
            checks++;
            if (mem_resp_replay !== 1'b0) begin
                failures++;
                $display("FAIL replay cycle=%0d got %b want 0", edges, mem_resp_replay);
            end
            checks++;
            if (s2_nack === 1'b1) begin
                if (nq.size() == 0 || nq[0] != edges) begin
                    failures++;
                    $display("FAIL unexpected_nack cycle=%0d", edges);
                end else begin
                    void'(nq.pop_front());
                end
            end else if (s2_nack !== 1'b0) begin
                failures++;
                $display("FAIL nack_level cycle=%0d got %b want 0/1", edges, s2_nack);
            end
        end
    end

    // One clock cycle of stimulus; the reference model predicts the effect of the coming edge.
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] t,
                        input logic w, input logic [63:0] wd, input logic ni, input logic st,
                        input logic bw, input logic [7:0] ba, input logic [63:0] bdd,
                        input logic rst);
        int   e;
        int   idx;
        bit   good;
        exp_t x;
        @(negedge clock);
        mem_req_valid = v; mem_req_addr = a; mem_req_tag = t; mem_req_wen = w;
        mem_wdata = wd; nack_inject = ni; stall = st;
        bd_wen = bw; bd_addr = ba; bd_wdata = bdd; reset = rst;
        #1;
        checks++;
        if (mem_req_ready !== (!rst && !st)) begin
            failures++;
            $display("FAIL ready cycle=%0d got %b want %b", edges, mem_req_ready, !rst && !st);
        end
        if (bd_chk) begin
            checks++;
            if (bd_rdata !== mref[ba]) begin
                failures++;
                $display("FAIL bd_rdata word=%0d got %h want %h", ba, bd_rdata, mref[ba]);
            end
        end
        e    = edges + 1;
        good = 0;
        idx  = 0;
        if (rst) begin
            rq.delete();
            nq.delete();
        end else if (v && !st) begin
            if ((a >> 3) >= 64'(DEPTH) || ni) begin
                nq.push_back(e + 1);
            end else begin
                idx    = int'(a >> 3);
                good   = 1;
                x.due  = e + LAT - 1;
                x.hd   = !w;
                x.data = w ? 64'd0 : mref[idx];
                x.tag  = t;
                rq.push_back(x);
            end
        end
        if (bw) mref[ba] = bdd;
        if (good && w) mref[idx] = wd;
    endtask

    task automatic req(input logic v, input logic [63:0] a, input logic [63:0] t,
                       input logic w, input logic [63:0] wd, input logic ni, input logic st);
        step(v, a, t, w, wd, ni, st, 1'b0, 8'($urandom_range(0, DEPTH-1)), 64'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(0, 0, 0, 0, 0, 0, 0);
    endtask

    logic        r_v, r_w, r_ni, r_st, r_bw, r_rst;
    logic [63:0] r_a, r_t, r_wd, r_bd;
    logic [7:0]  r_ba;

    initial begin
        // Preload the whole array through the backdoor while held in reset.
        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 0, 0, 0, 0, 0, 1'b1, 8'(i), {$urandom, $urandom}, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 1'b0, 8'd0, 64'd0, 1'b1);
        mon_en = 1;
        bd_chk = 1;
        step(0, 0, 0, 0, 0, 0, 0, 1'b0, 8'd0, 64'd0, 1'b1);

        step(0, 0, 0, 0, 0, 0, 0, 1'b1, 8'd5, 64'h0123456789ABCDEF, 1'b0);
        req(1, 64'h28, 64'd7, 0, 0, 0, 0);
        idle(LAT + 1);

        req(1, 64'h10, 64'd1, 1, 64'hDEAD, 0, 0);
        req(1, 64'h10, 64'd2, 0, 0, 0, 0);
        idle(LAT + 1);

        req(1, 64'h800, 64'd3, 0, 0, 0, 0);
        req(1, 64'h28, 64'd4, 0, 0, 1, 0);
        req(1, 64'h28, 64'd5, 0, 0, 0, 0);
        req(1, 64'h8000_0000_0000_0010, 64'd6, 1, 64'hBAD, 0, 0);
        idle(LAT + 1);

        for (int i = 0; i < 8; i++) req(1, 64'(i * 8), 64'(100 + i), 0, 0, 0, 0);
        idle(LAT + 1);

        for (int i = 0; i < 3; i++) req(1, 64'h30, 64'd20, 0, 0, 0, 1);
        req(1, 64'h30, 64'd20, 0, 0, 0, 0);
        idle(LAT + 1);

        req(1, 64'h28, 64'd30, 0, 0, 0, 0);
        step(1, 64'h28, 64'd31, 0, 0, 0, 0, 1'b0, 8'd0, 64'd0, 1'b1);
        req(1, 64'h10, 64'd32, 0, 0, 0, 0);
        idle(LAT + 2);

        step(1, 64'h40, 64'd40, 1, 64'hAAAA, 0, 0, 1'b1, 8'd8, 64'h5555, 1'b0);
        req(1, 64'h40, 64'd41, 0, 0, 0, 0);
        req(1, 64'h7F8, 64'd42, 0, 0, 0, 0);
        idle(LAT + 1);

        for (int n = 0; n < 1500; n++) begin
            r_v   = ($urandom_range(0, 9) < 7);
            r_w   = $urandom_range(0, 1);
            r_ni  = ($urandom_range(0, 9) == 0);
            r_st  = ($urandom_range(0, 99) < 15);
            r_bw  = ($urandom_range(0, 9) == 0);
            r_rst = ($urandom_range(0, 99) == 0);
            r_ba  = 8'($urandom_range(0, DEPTH-1));
            r_bd  = {$urandom, $urandom};
            r_t   = {$urandom, $urandom};
            r_wd  = {$urandom, $urandom};
            if ($urandom_range(0, 9) < 8)
                r_a = 64'($urandom_range(0, DEPTH*8 - 1));
            else
                r_a = (64'd1 << $urandom_range(11, 63)) | 64'($urandom_range(0, 2047));
            step(r_v, r_a, r_t, r_w, r_wd, r_ni, r_st, r_bw, r_ba, r_bd, r_rst);
        end
        idle(LAT + 3);

        checks++;
        if (rq.size() != 0 || nq.size() != 0) begin
            failures++;
            $display("FAIL drain pending resp=%0d nack=%0d want 0", rq.size(), nq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
